// File: rtl/control_sequencer_if.sv
// Datapath-facing bus of the control sequencer: shared data bus plus the
// one-hot control strobes that steer each datapath stage.
interface control_sequencer_if;
  logic [15:0] busIN;
  logic [15:0] busOUT;
  logic        PC_OUT;
  logic        increment;
  logic        MAR_IN;
  logic        RAM_OUT;
  logic        RAM_IN;
  logic        IR_IN;
  logic        IR_OUT;
  logic        ACC_IN;
  logic        ACC_OUT;
  logic        B_IN;
  logic        ALU_OUT;
  logic        SUB;
  logic        OUT_IN;

  // The sequencer drives strobes and the operand address onto the bus.
  modport master (
    input  busIN,
    output busOUT, PC_OUT, increment, MAR_IN, RAM_OUT, RAM_IN, IR_IN, IR_OUT,
           ACC_IN, ACC_OUT, B_IN, ALU_OUT, SUB, OUT_IN
  );

  modport slave (
    output busIN,
    input  busOUT, PC_OUT, increment, MAR_IN, RAM_OUT, RAM_IN, IR_IN, IR_OUT,
           ACC_IN, ACC_OUT, B_IN, ALU_OUT, SUB, OUT_IN
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded-style control sequencer for a simple accumulator CPU: fetch, decode, 3 exec states.
// Optional macro CTRL_SEQ_EARLY_END_EN returns to fetch after the last strobe-bearing exec state.
module control_sequencer (
  input  logic                       clk,
  input  logic                       reset,
  control_sequencer_if.master        bus,
  output logic [3:0]                 opcode,
  output logic [2:0]                 tstate,
  output logic                       halted
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_STA = 4'h4;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    FETCH_ADDR  = 3'd0,
    FETCH_INSTR = 3'd1,
    EXEC1       = 3'd2,
    EXEC2       = 3'd3,
    EXEC3       = 3'd4,
    HALT        = 3'd7
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic increment;
    logic mar_in;
    logic ram_out;
    logic ram_in;
    logic ir_in;
    logic ir_out;
    logic acc_in;
    logic acc_out;
    logic b_in;
    logic alu_out;
    logic sub;
    logic out_in;
  } strobe_t;

  state_t              state;
  logic [DATA_W-1:0]   ir;
  logic                armed;
  strobe_t             strb;

  // Instructions that use the memory operand path (address phase in EXEC1).
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
  endfunction

  // Next state; 'run' is low only on the first edge after reset so FETCH_ADDR gets a full strobe cycle.
  function automatic state_t next_state(input state_t st, input logic [DATA_W-1:0] ins,
                                        input logic run);
    logic [OP_W-1:0] op;
    state_t          ns;
    op = ins[DATA_W-1 -: OP_W];
    ns = FETCH_ADDR;
    if (run) begin
      case (st)
        FETCH_ADDR:  ns = FETCH_INSTR;
        FETCH_INSTR: ns = EXEC1;
        EXEC1: begin
          if (op == OP_HLT) begin
            ns = HALT;
          end else begin
`ifdef CTRL_SEQ_EARLY_END_EN
            ns = is_mem_op(op) ? EXEC2 : FETCH_ADDR;
`else
            ns = EXEC2;
`endif
          end
        end
        EXEC2: begin
`ifdef CTRL_SEQ_EARLY_END_EN
          ns = ((op == OP_ADD) || (op == OP_SUB)) ? EXEC3 : FETCH_ADDR;
`else
          ns = EXEC3;
`endif
        end
        EXEC3:   ns = FETCH_ADDR;
        HALT:    ns = HALT;
        default: ns = FETCH_ADDR;
      endcase
    end
    return ns;
  endfunction

  // IR captures the bus on the edge that ends FETCH_INSTR.
  function automatic logic [DATA_W-1:0] next_ir(input state_t st, input logic [DATA_W-1:0] ins,
                                                input logic run, input logic [DATA_W-1:0] din);
    return (run && (st == FETCH_INSTR)) ? din : ins;
  endfunction

  // Strobe decode for a given state and instruction word.
  function automatic strobe_t decode(input state_t st, input logic [DATA_W-1:0] ins);
    logic [OP_W-1:0] op;
    strobe_t         s;
    op = ins[DATA_W-1 -: OP_W];
    s  = '0;
    case (st)
      FETCH_ADDR: begin
        s.pc_out = 1'b1;
        s.mar_in = 1'b1;
      end
      FETCH_INSTR: begin
        s.ram_out   = 1'b1;
        s.ir_in     = 1'b1;
        s.increment = 1'b1;
      end
      EXEC1: begin
        if (is_mem_op(op)) begin
          s.ir_out = 1'b1;
          s.mar_in = 1'b1;
        end else if (op == OP_OUT) begin
          s.acc_out = 1'b1;
          s.out_in  = 1'b1;
        end
      end
      EXEC2: begin
        case (op)
          OP_LDA: begin
            s.ram_out = 1'b1;
            s.acc_in  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            s.ram_out = 1'b1;
            s.b_in    = 1'b1;
          end
          OP_STA: begin
            s.acc_out = 1'b1;
            s.ram_in  = 1'b1;
          end
          default: s = '0;
        endcase
      end
      EXEC3: begin
        if ((op == OP_ADD) || (op == OP_SUB)) begin
          s.alu_out = 1'b1;
          s.acc_in  = 1'b1;
          s.sub     = (op == OP_SUB);
        end
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  // Sequencer state, IR and registered strobes; strobes are pre-decoded from the upcoming state/IR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FETCH_ADDR;
      ir     <= '0;
      armed  <= 1'b0;
      strb   <= '0;
      halted <= 1'b0;
    end else begin
      armed  <= 1'b1;
      state  <= next_state(state, ir, armed);
      ir     <= next_ir(state, ir, armed, bus.busIN);
      strb   <= decode(next_state(state, ir, armed), next_ir(state, ir, armed, bus.busIN));
      halted <= (next_state(state, ir, armed) == HALT);
    end
  end

  assign opcode = ir[DATA_W-1 -: OP_W];
  assign tstate = state;

  assign bus.busOUT    = strb.ir_out ? {(DATA_W-ADDR_W)'(0), ir[ADDR_W-1:0]} : {DATA_W{1'bz}};
  assign bus.PC_OUT    = strb.pc_out;
  assign bus.increment = strb.increment;
  assign bus.MAR_IN    = strb.mar_in;
  assign bus.RAM_OUT   = strb.ram_out;
  assign bus.RAM_IN    = strb.ram_in;
  assign bus.IR_IN     = strb.ir_in;
  assign bus.IR_OUT    = strb.ir_out;
  assign bus.ACC_IN    = strb.acc_in;
  assign bus.ACC_OUT   = strb.acc_out;
  assign bus.B_IN      = strb.b_in;
  assign bus.ALU_OUT   = strb.alu_out;
  assign bus.SUB       = strb.sub;
  assign bus.OUT_IN    = strb.out_in;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks LDA/SUB/ADD/OUT/undefined/STA/HLT with
// hand-computed strobe patterns per cycle, plus async reset mid-instruction and out of HALT.
module tb_control_sequencer;

  localparam logic [12:0] S_PC    = 13'h1000;
  localparam logic [12:0] S_INC   = 13'h0800;
  localparam logic [12:0] S_MAR   = 13'h0400;
  localparam logic [12:0] S_ROUT  = 13'h0200;
  localparam logic [12:0] S_RIN   = 13'h0100;
  localparam logic [12:0] S_IRIN  = 13'h0080;
  localparam logic [12:0] S_IROUT = 13'h0040;
  localparam logic [12:0] S_AIN   = 13'h0020;
  localparam logic [12:0] S_AOUT  = 13'h0010;
  localparam logic [12:0] S_BIN   = 13'h0008;
  localparam logic [12:0] S_ALU   = 13'h0004;
  localparam logic [12:0] S_SUB   = 13'h0002;
  localparam logic [12:0] S_OUTIN = 13'h0001;
  localparam logic [12:0] S_NONE  = 13'h0000;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic [2:0] tstate;
  logic       halted;
  logic [12:0] strb_obs;

  int n_cmp;
  int n_bad;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .opcode (opcode),
    .tstate (tstate),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign strb_obs = {bus.PC_OUT, bus.increment, bus.MAR_IN, bus.RAM_OUT, bus.RAM_IN,
                     bus.IR_IN, bus.IR_OUT, bus.ACC_IN, bus.ACC_OUT, bus.B_IN,
                     bus.ALU_OUT, bus.SUB, bus.OUT_IN};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle, then check state encoding and the full strobe vector.
  task automatic cyc(input string tag, input logic [2:0] exp_state, input logic [12:0] exp_strb);
    step();
    chk({tag, "_tstate"}, 16'(tstate), 16'(exp_state));
    chk({tag, "_strb"}, 16'(strb_obs), 16'(exp_strb));
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b0;
    bus.busIN  = 16'h0000;

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strb", 16'(strb_obs), 16'(S_NONE));
    chk("rst_tstate", 16'(tstate), 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_opcode", 16'(opcode), 16'h0);
    @(negedge clk);
    reset = 1'b1;

    // LDA 0xABC
    bus.busIN = 16'h1ABC;
    cyc("lda_fa", 3'd0, S_PC | S_MAR);
    cyc("lda_fi", 3'd1, S_ROUT | S_IRIN | S_INC);
    cyc("lda_e1", 3'd2, S_IROUT | S_MAR);
    chk("lda_opcode", 16'(opcode), 16'h1);
    chk("lda_busout", bus.busOUT, 16'h0ABC);
    cyc("lda_e2", 3'd3, S_ROUT | S_AIN);
`ifndef CTRL_SEQ_EARLY_END_EN
    cyc("lda_e3", 3'd4, S_NONE);
`endif

    // SUB 0x010
    bus.busIN = 16'h3010;
    cyc("sub_fa", 3'd0, S_PC | S_MAR);
    cyc("sub_fi", 3'd1, S_ROUT | S_IRIN | S_INC);
    cyc("sub_e1", 3'd2, S_IROUT | S_MAR);
    chk("sub_busout", bus.busOUT, 16'h0010);
    cyc("sub_e2", 3'd3, S_ROUT | S_BIN);
    cyc("sub_e3", 3'd4, S_ALU | S_AIN | S_SUB);

    // ADD 0x010
    bus.busIN = 16'h2010;
    cyc("add_fa", 3'd0, S_PC | S_MAR);
    cyc("add_fi", 3'd1, S_ROUT | S_IRIN | S_INC);
    cyc("add_e1", 3'd2, S_IROUT | S_MAR);
    cyc("add_e2", 3'd3, S_ROUT | S_BIN);
    cyc("add_e3", 3'd4, S_ALU | S_AIN);

    // OUT
    bus.busIN = 16'hE000;
    cyc("out_fa", 3'd0, S_PC | S_MAR);
    cyc("out_fi", 3'd1, S_ROUT | S_IRIN | S_INC);
    cyc("out_e1", 3'd2, S_AOUT | S_OUTIN);
    chk("out_opcode", 16'(opcode), 16'hE);
`ifndef CTRL_SEQ_EARLY_END_EN
    cyc("out_e2", 3'd3, S_NONE);
    cyc("out_e3", 3'd4, S_NONE);
`endif

    // Undefined opcode 7 behaves as NOP
    bus.busIN = 16'h7123;
    cyc("undef_fa", 3'd0, S_PC | S_MAR);
    cyc("undef_fi", 3'd1, S_ROUT | S_IRIN | S_INC);
    cyc("undef_e1", 3'd2, S_NONE);
`ifndef CTRL_SEQ_EARLY_END_EN
    cyc("undef_e2", 3'd3, S_NONE);
    cyc("undef_e3", 3'd4, S_NONE);
`endif

    // STA aborted by reset during EXEC2
    bus.busIN = 16'h4123;
    cyc("sta_fa", 3'd0, S_PC | S_MAR);
    cyc("sta_fi", 3'd1, S_ROUT | S_IRIN | S_INC);
    cyc("sta_e1", 3'd2, S_IROUT | S_MAR);
    chk("sta_busout", bus.busOUT, 16'h0123);
    cyc("sta_e2", 3'd3, S_AOUT | S_RIN);
    #2;
    reset = 1'b0;
    #1;
    chk("sta_abort_ramin", 16'(bus.RAM_IN), 16'h0);
    chk("sta_abort_strb", 16'(strb_obs), 16'(S_NONE));
    chk("sta_abort_opcode", 16'(opcode), 16'h0);
    chk("sta_abort_tstate", 16'(tstate), 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // HLT then 20 halted cycles
    bus.busIN = 16'hF000;
    cyc("hlt_fa", 3'd0, S_PC | S_MAR);
    cyc("hlt_fi", 3'd1, S_ROUT | S_IRIN | S_INC);
    cyc("hlt_e1", 3'd2, S_NONE);
    chk("hlt_e1_halted", 16'(halted), 16'h0);
    bus.busIN = 16'h1ABC;
    for (int i = 0; i < 20; i++) begin
      cyc("halt", 3'd7, S_NONE);
      chk("halt_flag", 16'(halted), 16'h1);
    end
    #2;
    reset = 1'b0;
    #1;
    chk("halt_rst_flag", 16'(halted), 16'h0);
    chk("halt_rst_tstate", 16'(tstate), 16'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc("post_halt_fa", 3'd0, S_PC | S_MAR);
    cyc("post_halt_fi", 3'd1, S_ROUT | S_IRIN | S_INC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
